// File: rtl/cache_2way_lru_if.sv
// rtl/cache_2way_lru_if.sv - CPU-side and memory-side handshake bundle for cache_2way_lru
interface cache_2way_lru_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 2,
  parameter int CNT_W  = 16
);
  localparam int BLK_W = 32 << WORD_W;

  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_hit;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  // Cache view: CPU requests and memory responses come in.
  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr, mem_wdata,
    output hit_count, miss_count
  );

  // Environment view: drives CPU requests and answers memory requests.
  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_rw, mem_addr, mem_wdata,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_2way_lru.sv
// rtl/cache_2way_lru.sv - write-back, write-allocate 2-way set-associative cache with 1-bit LRU
module cache_2way_lru #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 1,
  parameter int WORD_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  cache_2way_lru_if.slave bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int BLK_W = 32 << WORD_W;
  localparam int TAG_W = ADDR_W - INDEX_W - WORD_W - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t state, next_state;

  logic [ADDR_W-1:0]    req_addr;
  logic                 req_rw;
  logic [31:0]          req_wdata;
  logic                 first_cmp;
  logic                 missed;
  logic                 victim_way;

  logic [SETS-1:0][1:0] valid;
  logic [SETS-1:0][1:0] dirty;
  logic [SETS-1:0]      lru;
  logic [TAG_W-1:0]     tag_mem  [2][SETS];
  logic [BLK_W-1:0]     data_mem [2][SETS];

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [WORD_W-1:0]    req_word;
  logic                 hit0, hit1, hit, hit_way;
  logic                 miss_victim, victim_dirty, mem_done;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[WORD_W+2 +: INDEX_W];
  assign req_word = req_addr[2 +: WORD_W];

  assign hit0    = valid[req_idx][0] && (tag_mem[0][req_idx] == req_tag);
  assign hit1    = valid[req_idx][1] && (tag_mem[1][req_idx] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  // Fill empty ways first; LRU only arbitrates once both ways are valid.
  assign miss_victim  = !valid[req_idx][0] ? 1'b0 :
                        (!valid[req_idx][1] ? 1'b1 : lru[req_idx]);
  assign victim_dirty = valid[req_idx][miss_victim] & dirty[req_idx][miss_victim];
  assign mem_done     = bus.mem_req & bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bus.cpu_req) next_state = COMPARE;
      COMPARE:   if (hit)          next_state = IDLE;
                 else if (victim_dirty) next_state = WRITEBACK;
                 else              next_state = ALLOCATE;
      WRITEBACK: if (mem_done) next_state = ALLOCATE;
      ALLOCATE:  if (mem_done) next_state = COMPARE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr       <= '0;
      req_rw         <= 1'b0;
      req_wdata      <= '0;
      first_cmp      <= 1'b0;
      missed         <= 1'b0;
      victim_way     <= 1'b0;
      valid          <= '0;
      dirty          <= '0;
      lru            <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_ready  <= 1'b0;
      bus.cpu_hit    <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_rw     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.cpu_hit   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            req_addr  <= bus.cpu_addr;
            req_rw    <= bus.cpu_rw;
            req_wdata <= bus.cpu_wdata;
            first_cmp <= 1'b1;
            missed    <= 1'b0;
          end
        end
        COMPARE: begin
          first_cmp <= 1'b0;
          // The post-fill COMPARE is not a new lookup and must not be counted.
          if (first_cmp) begin
            if (hit) begin
              if (~&bus.hit_count) bus.hit_count <= bus.hit_count + 1'b1;
            end else begin
              if (~&bus.miss_count) bus.miss_count <= bus.miss_count + 1'b1;
            end
          end
          if (hit) begin
            if (req_rw) dirty[req_idx][hit_way] <= 1'b1;
            else        bus.cpu_rdata <= data_mem[hit_way][req_idx][{req_word, 5'd0} +: 32];
            lru[req_idx]  <= ~hit_way;
            bus.cpu_ready <= 1'b1;
            bus.cpu_hit   <= ~missed;
          end else begin
            missed      <= 1'b1;
            victim_way  <= miss_victim;
            bus.mem_req <= 1'b1;
            if (victim_dirty) begin
              bus.mem_rw    <= 1'b1;
              bus.mem_addr  <= {tag_mem[miss_victim][req_idx], req_idx, {(WORD_W+2){1'b0}}};
              bus.mem_wdata <= data_mem[miss_victim][req_idx];
            end else begin
              bus.mem_rw   <= 1'b0;
              bus.mem_addr <= {req_tag, req_idx, {(WORD_W+2){1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_done) begin
            dirty[req_idx][victim_way] <= 1'b0;
            bus.mem_rw   <= 1'b0;
            bus.mem_addr <= {req_tag, req_idx, {(WORD_W+2){1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_done) begin
            bus.mem_req                <= 1'b0;
            valid[req_idx][victim_way] <= 1'b1;
            dirty[req_idx][victim_way] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays are left uninitialised; V bits gate their use.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_rw)
      data_mem[hit_way][req_idx][{req_word, 5'd0} +: 32] <= req_wdata;
    if (state == ALLOCATE && mem_done) begin
      data_mem[victim_way][req_idx] <= bus.mem_rdata;
      tag_mem[victim_way][req_idx]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_cache_2way_lru.sv
// tb/tb_cache_2way_lru.sv - self-checking bench for cache_2way_lru using a per-set recency-list model
module tb_cache_2way_lru;
  localparam int ADDR_W  = 10;
  localparam int INDEX_W = 1;
  localparam int WORD_W  = 2;
  localparam int CNT_W   = 16;
  localparam int SETS    = 1 << INDEX_W;
  localparam int BLK_W   = 32 << WORD_W;
  localparam int TAG_W   = ADDR_W - INDEX_W - WORD_W - 2;
  localparam int NBLK    = 1 << (ADDR_W - WORD_W - 2);

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             dirty;
    logic [BLK_W-1:0] data;
  } line_t;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [BLK_W-1:0]  data;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_2way_lru_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  cache_2way_lru #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  line_t            lines [SETS][$];
  logic [BLK_W-1:0] gold_ram [NBLK];
  logic [BLK_W-1:0] ram [NBLK];
  txn_t             log_q[$];
  txn_t             exp_q[$];
  int               n_pass = 0;
  int               n_total = 0;
  int               m_hits = 0;
  int               m_misses = 0;
  int               last_base = 0;
  bit               resp_hold = 1'b0;
  bit               resp_random = 1'b0;

  function automatic logic [BLK_W-1:0] init_block(input int b);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int w = 0; w < (1 << WORD_W); w++)
      v[32*w +: 32] = {4{8'(w * 17)}} ^ 32'(b << (WORD_W + 2));
    return v;
  endfunction

  task automatic check(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Memory responder: random or zero wait, optionally holding off block reads.
  initial begin : responder
    int   wait_cnt;
    int   cur_delay;
    txn_t t;
    int   blk;
    wait_cnt = 0;
    cur_delay = 0;
    for (int b = 0; b < NBLK; b++) ram[b] = init_block(b);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (reset || !bus.mem_req || (resp_hold && !bus.mem_rw)) begin
        wait_cnt = 0;
      end else if (wait_cnt < (resp_random ? cur_delay : 0)) begin
        wait_cnt++;
      end else begin
        t.rw = bus.mem_rw;
        t.addr = bus.mem_addr;
        t.data = bus.mem_wdata;
        log_q.push_back(t);
        blk = int'(bus.mem_addr >> (WORD_W + 2));
        if (bus.mem_rw) ram[blk] = bus.mem_wdata;
        else            bus.mem_rdata = ram[blk];
        bus.mem_ready = 1'b1;
        wait_cnt = 0;
        cur_delay = $urandom_range(0, 3);
      end
    end
  end

  // Reference: each set is a recency-ordered list (front = most recent) of at most two lines.
  task automatic model_access(input logic rw, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                              output logic hit, output logic [31:0] rdata);
    int               idx, w, found, blk;
    logic [TAG_W-1:0] tag;
    line_t            ln;
    txn_t             t;
    idx = int'(addr[WORD_W+2 +: INDEX_W]);
    tag = addr[ADDR_W-1 -: TAG_W];
    w   = int'(addr[2 +: WORD_W]);
    blk = int'(addr >> (WORD_W + 2));
    exp_q.delete();
    rdata = '0;
    found = -1;
    for (int i = 0; i < lines[idx].size(); i++)
      if (lines[idx][i].tag == tag) found = i;
    if (found >= 0) begin
      hit = 1'b1;
      ln = lines[idx][found];
      lines[idx].delete(found);
      m_hits++;
    end else begin
      hit = 1'b0;
      m_misses++;
      if (lines[idx].size() == 2) begin
        ln = lines[idx].pop_back();
        if (ln.dirty) begin
          t.rw = 1'b1;
          t.addr = {ln.tag, addr[WORD_W+2 +: INDEX_W], {(WORD_W+2){1'b0}}};
          t.data = ln.data;
          exp_q.push_back(t);
          gold_ram[int'(t.addr >> (WORD_W + 2))] = ln.data;
        end
      end
      ln.tag = tag;
      ln.dirty = 1'b0;
      ln.data = gold_ram[blk];
      t.rw = 1'b0;
      t.addr = {addr[ADDR_W-1:WORD_W+2], {(WORD_W+2){1'b0}}};
      t.data = '0;
      exp_q.push_back(t);
    end
    if (rw) begin
      ln.data[32*w +: 32] = wdata;
      ln.dirty = 1'b1;
    end else begin
      rdata = ln.data[32*w +: 32];
    end
    lines[idx].push_front(ln);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) lines[s].delete();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_rw = rw;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_rw = 1'($urandom);
    bus.cpu_addr = ADDR_W'($urandom);
    bus.cpu_wdata = $urandom;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 1;
    while (!bus.cpu_ready && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check("ready_seen", BLK_W'(bus.cpu_ready), BLK_W'(1));
  endtask

  task automatic finish_access(input logic rw, input logic exp_hit, input logic [31:0] exp_rdata, input int base);
    txn_t a;
    check("cpu_hit", BLK_W'(bus.cpu_hit), BLK_W'(exp_hit));
    if (!rw) check("cpu_rdata", BLK_W'(bus.cpu_rdata), BLK_W'(exp_rdata));
    check("txn_count", BLK_W'(log_q.size() - base), BLK_W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      a = log_q[base + i];
      check("txn_rw", BLK_W'(a.rw), BLK_W'(exp_q[i].rw));
      check("txn_addr", BLK_W'(a.addr), BLK_W'(exp_q[i].addr));
      if (exp_q[i].rw) check("txn_wdata", a.data, exp_q[i].data);
    end
    check("hit_count", BLK_W'(bus.hit_count), BLK_W'(m_hits));
    check("miss_count", BLK_W'(bus.miss_count), BLK_W'(m_misses));
  endtask

  task automatic do_access(input logic rw, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    logic        eh;
    logic [31:0] er;
    int          cyc;
    model_access(rw, addr, wdata, eh, er);
    last_base = log_q.size();
    issue(rw, addr, wdata);
    wait_ready(cyc);
    if (eh) check("hit_latency", BLK_W'(cyc), BLK_W'(2));
    finish_access(rw, eh, er, last_base);
  endtask

  initial begin : main
    logic        eh;
    logic [31:0] er;
    int          cyc, b3, seen;
    txn_t        a;
    logic [ADDR_W-1:0] ra;

    bus.cpu_req = 1'b0;
    bus.cpu_rw = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    for (int b = 0; b < NBLK; b++) gold_ram[b] = init_block(b);

    repeat (3) @(negedge clk);
    check("rst_cpu_ready", BLK_W'(bus.cpu_ready), BLK_W'(0));
    check("rst_mem_req", BLK_W'(bus.mem_req), BLK_W'(0));
    check("rst_cpu_rdata", BLK_W'(bus.cpu_rdata), BLK_W'(0));
    check("rst_hit_count", BLK_W'(bus.hit_count), BLK_W'(0));
    check("rst_miss_count", BLK_W'(bus.miss_count), BLK_W'(0));
    reset = 1'b0;

    // Cold read miss then a hit in the same block.
    do_access(1'b0, 10'h004, 32'h0);
    check("t1_rdata", BLK_W'(bus.cpu_rdata), BLK_W'(32'h11111111));
    check("t1_miss_count", BLK_W'(bus.miss_count), BLK_W'(1));
    a = log_q[last_base];
    check("t1_fill_addr", BLK_W'(a.addr), BLK_W'(10'h000));
    do_access(1'b0, 10'h008, 32'h0);
    check("t2_rdata", BLK_W'(bus.cpu_rdata), BLK_W'(32'h22222222));
    check("t2_hit_count", BLK_W'(bus.hit_count), BLK_W'(1));

    b3 = log_q.size();
    do_access(1'b1, 10'h00C, 32'hDEADBEEF);
    do_access(1'b0, 10'h00C, 32'h0);
    check("t3_rdata", BLK_W'(bus.cpu_rdata), BLK_W'(32'hDEADBEEF));
    check("t3_no_traffic", BLK_W'(log_q.size() - b3), BLK_W'(0));

    // Clean LRU eviction, then dirty eviction with write-back.
    do_access(1'b0, 10'h080, 32'h0);
    do_access(1'b0, 10'h000, 32'h0);
    do_access(1'b0, 10'h100, 32'h0);
    check("t4_clean_evict_txns", BLK_W'(log_q.size() - last_base), BLK_W'(1));
    a = log_q[last_base];
    check("t4_fill100", BLK_W'(a.addr), BLK_W'(10'h100));
    do_access(1'b0, 10'h080, 32'h0);
    a = log_q[last_base];
    check("t4_wb_rw", BLK_W'(a.rw), BLK_W'(1));
    check("t4_wb_addr", BLK_W'(a.addr), BLK_W'(10'h000));
    check("t4_wb_word3", BLK_W'(a.data[127:96]), BLK_W'(32'hDEADBEEF));
    a = log_q[last_base + 1];
    check("t4_fill080", BLK_W'(a.addr), BLK_W'(10'h080));

    // Memory stalls in ALLOCATE.
    model_access(1'b0, 10'h014, 32'h0, eh, er);
    last_base = log_q.size();
    resp_hold = 1'b1;
    issue(1'b0, 10'h014, 32'h0);
    cyc = 0;
    while (!(bus.mem_req && !bus.mem_rw) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_alloc_seen", BLK_W'(bus.mem_req), BLK_W'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_req_held", BLK_W'(bus.mem_req), BLK_W'(1));
      check("t5_addr_held", BLK_W'(bus.mem_addr), BLK_W'(10'h010));
      check("t5_no_ready", BLK_W'(bus.cpu_ready), BLK_W'(0));
    end
    @(posedge clk);
    resp_hold = 1'b0;
    @(negedge clk);
    wait_ready(cyc);
    finish_access(1'b0, eh, er, last_base);

    // Reset during ALLOCATE aborts the request.
    resp_hold = 1'b1;
    issue(1'b0, 10'h024, 32'h0);
    cyc = 0;
    while (!(bus.mem_req && !bus.mem_rw) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_alloc_seen", BLK_W'(bus.mem_req), BLK_W'(1));
    #2 reset = 1'b1;
    #1;
    check("t6_mem_req_drop", BLK_W'(bus.mem_req), BLK_W'(0));
    check("t6_hit_count", BLK_W'(bus.hit_count), BLK_W'(0));
    check("t6_miss_count", BLK_W'(bus.miss_count), BLK_W'(0));
    model_reset();
    resp_hold = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.cpu_ready) seen++;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.cpu_ready || bus.mem_req) seen++;
    end
    check("t6_quiet_after_reset", BLK_W'(seen), BLK_W'(0));
    do_access(1'b0, 10'h024, 32'h0);
    check("t6_reread_miss", BLK_W'(bus.cpu_hit), BLK_W'(0));

    // Randomised traffic over a few conflicting tags.
    resp_random = 1'b1;
    for (int n = 0; n < 200; n++) begin
      ra = ADDR_W'(($urandom_range(0, 3) << (ADDR_W - TAG_W)) | $urandom_range(0, (1 << (ADDR_W - TAG_W)) - 1));
      do_access(1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
